// File: rtl/lock_guard.sv
// Front-end guard for combo_lock: synchronises user inputs, shapes enter pulses,
// enforces a lockout after repeated failures and auto-relocks an idle open lock.
module lock_guard #(
   parameter int unsigned MAX_FAILS      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 50000000,
   parameter int unsigned RELOCK_CYCLES  = 250000000,
   parameter int unsigned TMR_W          = 28
) (
   input  logic       clk,
   input  logic       hard_rst_n,
   input  logic [9:0] keypad_in,
   input  logic       enter_in,
   input  logic       clr_in,
   input  logic       rst_in,
   input  logic       unlock,
   input  logic       incorrect,
   output logic [9:0] keypad_out,
   output logic       enter_out,
   output logic       clr_out,
   output logic       rst_out,
   output logic       lockout,
   output logic [3:0] fail_count
);

   localparam logic [1:0] ARMED   = 2'd0;
   localparam logic [1:0] OPEN    = 2'd1;
   localparam logic [1:0] LOCKOUT = 2'd2;
   localparam logic [1:0] RELOCK  = 2'd3;

   localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(RELOCK_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
   localparam logic [3:0]       FAIL_MAX  = 4'(MAX_FAILS);
   localparam logic [3:0]       FAIL_TRIP = 4'(MAX_FAILS - 1);

   logic [9:0]       key_s1, key_s2;
   logic             ent_s1, ent_s2, ent_prev;
   logic             clr_s1, clr_s2;
   logic             rst_s1, rst_s2;
   logic             inc_prev, unl_prev;
   logic [1:0]       state, state_nx;
   logic [TMR_W-1:0] timer, timer_nx;
   logic [3:0]       fail_nx;
   logic             ent_edge, inc_edge, unl_edge, activity, gate;

   always_comb begin
      ent_edge = ent_s2 & ~ent_prev;
      inc_edge = incorrect & ~inc_prev;
      unl_edge = unlock & ~unl_prev;
      activity = (|key_s2) | ent_s2 | clr_s2 | rst_s2;
      state_nx = state;
      timer_nx = timer;
      case (state)
         ARMED: begin
            if (unlock) begin
               state_nx = OPEN;
               timer_nx = OPEN_LOAD;
            end else if (inc_edge && !unl_edge && fail_count >= FAIL_TRIP) begin
               state_nx = LOCKOUT;
               timer_nx = LOCK_LOAD;
            end
         end
         OPEN: begin
            if (!unlock)
               state_nx = ARMED;
            else if (activity)
               timer_nx = OPEN_LOAD;
            else if (timer == '0)
               state_nx = RELOCK;
            else
               timer_nx = timer - TMR_W'(1);
         end
         RELOCK: state_nx = ARMED;
         LOCKOUT: begin
            if (timer == '0)
               state_nx = ARMED;
            else
               timer_nx = timer - TMR_W'(1);
         end
      endcase

      // unlock edge outranks a simultaneous incorrect edge
      fail_nx = fail_count;
      if (unl_edge)
         fail_nx = '0;
      else if (state == LOCKOUT && state_nx == ARMED)
         fail_nx = '0;
      else if (inc_edge && fail_count < FAIL_MAX)
         fail_nx = fail_count + 4'd1;

      gate = (state_nx != LOCKOUT);
   end

   always_ff @(posedge clk or negedge hard_rst_n) begin
      if (!hard_rst_n) begin
         key_s1     <= '0;
         key_s2     <= '0;
         ent_s1     <= 1'b0;
         ent_s2     <= 1'b0;
         ent_prev   <= 1'b0;
         clr_s1     <= 1'b0;
         clr_s2     <= 1'b0;
         rst_s1     <= 1'b0;
         rst_s2     <= 1'b0;
         inc_prev   <= 1'b0;
         unl_prev   <= 1'b0;
         state      <= ARMED;
         timer      <= '0;
         fail_count <= '0;
         keypad_out <= '0;
         enter_out  <= 1'b0;
         clr_out    <= 1'b0;
         rst_out    <= 1'b0;
         lockout    <= 1'b0;
      end else begin
         key_s1     <= keypad_in;
         key_s2     <= key_s1;
         ent_s1     <= enter_in;
         ent_s2     <= ent_s1;
         ent_prev   <= ent_s2;
         clr_s1     <= clr_in;
         clr_s2     <= clr_s1;
         rst_s1     <= rst_in;
         rst_s2     <= rst_s1;
         inc_prev   <= incorrect;
         unl_prev   <= unlock;
         state      <= state_nx;
         timer      <= timer_nx;
         fail_count <= fail_nx;
         // gating on the next state keeps outputs low for every LOCKOUT cycle
         keypad_out <= gate ? key_s2 : '0;
         clr_out    <= gate & clr_s2;
         rst_out    <= gate & rst_s2;
         enter_out  <= (ent_edge & gate) | (state_nx == RELOCK);
         lockout    <= (state_nx == LOCKOUT);
      end
   end

endmodule

// File: tb/tb_lock_guard.sv
// Directed bench for lock_guard with short lockout/relock timers.
module tb_lock_guard;

   logic       clk = 1'b0;
   logic       hard_rst_n;
   logic [9:0] keypad_in;
   logic       enter_in, clr_in, rst_in, unlock, incorrect;
   logic [9:0] keypad_out;
   logic       enter_out, clr_out, rst_out, lockout;
   logic [3:0] fail_count;

   int nvec = 0;
   int nerr = 0;
   int pulses;
   int pulse_at;

   always #5 clk = ~clk;

   lock_guard #(
      .MAX_FAILS(3),
      .LOCKOUT_CYCLES(20),
      .RELOCK_CYCLES(50),
      .TMR_W(28)
   ) dut (
      .clk(clk),
      .hard_rst_n(hard_rst_n),
      .keypad_in(keypad_in),
      .enter_in(enter_in),
      .clr_in(clr_in),
      .rst_in(rst_in),
      .unlock(unlock),
      .incorrect(incorrect),
      .keypad_out(keypad_out),
      .enter_out(enter_out),
      .clr_out(clr_out),
      .rst_out(rst_out),
      .lockout(lockout),
      .fail_count(fail_count)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_inc(input string tag, input logic [3:0] exp_fc, input logic exp_lo);
      incorrect = 1'b1;
      tick(1);
      chk({tag, "_fc"}, 32'(fail_count), 32'(exp_fc));
      chk({tag, "_lockout"}, 32'(lockout), 32'(exp_lo));
      incorrect = 1'b0;
   endtask

   initial begin
      hard_rst_n = 1'b0;
      keypad_in  = '0;
      enter_in   = 1'b0;
      clr_in     = 1'b0;
      rst_in     = 1'b0;
      unlock     = 1'b0;
      incorrect  = 1'b0;
      tick(3);
      chk("rst_keypad", 32'(keypad_out), 32'h0);
      chk("rst_outs", {28'h0, enter_out, clr_out, rst_out, lockout}, 32'h0);
      chk("rst_fc", 32'(fail_count), 32'h0);
      hard_rst_n = 1'b1;
      tick(2);
      chk("post_rst_outs", {18'h0, keypad_out, enter_out, clr_out, rst_out, lockout}, 32'h0);

      // input path latency: raw sampled at edge k, output after edge k+2
      keypad_in = 10'h200;
      clr_in    = 1'b1;
      rst_in    = 1'b1;
      tick(2);
      chk("key_lat_early", 32'(keypad_out), 32'h0);
      chk("clr_lat_early", 32'(clr_out), 32'h0);
      tick(1);
      chk("key_lat", 32'(keypad_out), 32'h200);
      chk("clr_rst_lat", {30'h0, clr_out, rst_out}, 32'h3);
      keypad_in = '0;
      clr_in    = 1'b0;
      rst_in    = 1'b0;
      tick(4);

      // 1: held enter gives one pulse
      enter_in = 1'b1;
      pulses   = 0;
      pulse_at = 0;
      for (int i = 1; i <= 12; i++) begin
         tick(1);
         if (enter_out) begin
            pulses++;
            pulse_at = i;
         end
      end
      chk("enter_pulses", 32'(pulses), 32'd1);
      chk("enter_latency", 32'(pulse_at), 32'd3);
      enter_in = 1'b0;
      tick(4);

      // 2: three failures -> lockout for 20 cycles
      pulse_inc("t2_inc1", 4'd1, 1'b0);
      tick(1);
      pulse_inc("t2_inc2", 4'd2, 1'b0);
      tick(1);
      pulse_inc("t2_inc3", 4'd3, 1'b1);
      keypad_in = 10'h004;
      for (int i = 1; i <= 19; i++) begin
         incorrect = (i == 5);
         tick(1);
         chk("t2_lockout_hold", 32'(lockout), 32'h1);
         chk("t2_key_gated", 32'(keypad_out), 32'h0);
         chk("t2_fc_sat", 32'(fail_count), 32'd3);
      end
      incorrect = 1'b0;
      tick(1);
      chk("t2_lockout_end", 32'(lockout), 32'h0);
      chk("t2_fc_clear", 32'(fail_count), 32'h0);
      chk("t2_key_release", 32'(keypad_out), 32'h004);
      keypad_in = '0;
      tick(4);

      // 3: unlock clears the count
      pulse_inc("t3_inc1", 4'd1, 1'b0);
      tick(1);
      pulse_inc("t3_inc2", 4'd2, 1'b0);
      unlock = 1'b1;
      tick(1);
      chk("t3_unlock_clr", 32'(fail_count), 32'h0);
      unlock = 1'b0;
      tick(2);
      pulse_inc("t3_inc3", 4'd1, 1'b0);
      tick(1);

      // 6: simultaneous incorrect and unlock at fail_count=2
      pulse_inc("t6_inc2", 4'd2, 1'b0);
      tick(1);
      incorrect = 1'b1;
      unlock    = 1'b1;
      tick(1);
      chk("t6_fc", 32'(fail_count), 32'h0);
      chk("t6_lockout", 32'(lockout), 32'h0);
      incorrect = 1'b0;
      unlock    = 1'b0;
      tick(3);
      chk("t6_lockout_later", 32'(lockout), 32'h0);

      // 4a: idle open lock relocks 50 cycles after entering OPEN
      unlock = 1'b1;
      tick(1);
      chk("t4_no_pulse_start", 32'(enter_out), 32'h0);
      tick(49);
      chk("t4_no_pulse_49", 32'(enter_out), 32'h0);
      tick(1);
      chk("t4_relock_pulse", 32'(enter_out), 32'h1);
      unlock = 1'b0;
      tick(1);
      chk("t4_pulse_single", 32'(enter_out), 32'h0);
      tick(3);

      // 4b: key activity at cycle 30 pushes the relock to cycle 80
      unlock = 1'b1;
      tick(1);
      tick(27);
      keypad_in = 10'h001;
      tick(1);
      keypad_in = '0;
      tick(22);
      chk("t4b_no_pulse_50", 32'(enter_out), 32'h0);
      tick(29);
      chk("t4b_no_pulse_79", 32'(enter_out), 32'h0);
      tick(1);
      chk("t4b_relock_pulse", 32'(enter_out), 32'h1);
      unlock = 1'b0;
      tick(1);
      chk("t4b_pulse_single", 32'(enter_out), 32'h0);
      tick(3);

      // 5: reset in the middle of a lockout
      pulse_inc("t5_inc1", 4'd1, 1'b0);
      tick(1);
      pulse_inc("t5_inc2", 4'd2, 1'b0);
      tick(1);
      pulse_inc("t5_inc3", 4'd3, 1'b1);
      keypad_in = 10'h010;
      tick(9);
      chk("t5_lockout_mid", 32'(lockout), 32'h1);
      hard_rst_n = 1'b0;
      keypad_in  = '0;
      #1;
      chk("t5_async_lockout", 32'(lockout), 32'h0);
      chk("t5_async_fc", 32'(fail_count), 32'h0);
      chk("t5_async_outs", {18'h0, keypad_out, enter_out, clr_out, rst_out, lockout}, 32'h0);
      tick(2);
      hard_rst_n = 1'b1;
      tick(2);
      chk("t5_after_rst", {18'h0, keypad_out, enter_out, clr_out, rst_out, lockout}, 32'h0);
      pulse_inc("t5_armed_inc", 4'd1, 1'b0);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
